mac_rx_framer: RTL and testbench

MAC_RX_FRAMER -- requirements
Module: mac_rx_framer

---
 rtl/mac_rx_framer.sv | 167 ++++++++++++++++
 tb/tb_mac_rx_framer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delays the stream by five bytes so the
// trailing FCS can be dropped, checks CRC-32 and frame length, and counts good/bad frames.
module mac_rx_framer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX_DV,
  input  logic        RX_ER,
  input  logic [7:0]  RXD,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  output logic        rx_err,
  output logic        rx_crc_err,
  output logic        rx_len_err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;
  localparam logic [7:0]  Preamble   = 8'h55;
  localparam logic [7:0]  Sfd        = 8'hD5;
  localparam logic [10:0] CntMax     = 11'h7FF;
  localparam logic [15:0] FrameMax   = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  state_e          state_q;
  logic [4:0][7:0] sr_q;         // [0] newest byte, [4] oldest
  logic [10:0]     cnt_q;
  logic [31:0]     crc_q;
  logic            err_q;
  // Cleared by reset; a burst already in flight when reset drops is ignored until
  // RX_DV has been seen low, so an aborted frame never reaches IDLE decoding.
  logic            dv_low_seen_q;

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CrcPoly;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic        cnt_ge5;
  logic [10:0] cnt_inc;
  logic [31:0] cnt_ext;
  logic        len_bad;
  logic        crc_bad;
  logic        frame_bad;
  logic [15:0] ok_inc;
  logic [15:0] bad_inc;

  // Decode helpers for the frame-end decision and saturating counters.
  always_comb begin
    cnt_ge5   = (cnt_q >= 11'd5);
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 11'd1;
    cnt_ext   = {21'd0, cnt_q};
    len_bad   = (cnt_ext < MIN_LEN) || (cnt_ext > MAX_LEN);
    crc_bad   = (crc_q != CrcResidue);
    frame_bad = err_q | crc_bad | len_bad;
    ok_inc    = (frames_ok == FrameMax) ? frames_ok : frames_ok + 16'd1;
    bad_inc   = (frames_bad == FrameMax) ? frames_bad : frames_bad + 16'd1;
  end

  // Framer FSM with registered outputs and frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      sr_q          <= '0;
      cnt_q         <= '0;
      crc_q         <= CrcInit;
      err_q         <= 1'b0;
      dv_low_seen_q <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_last       <= 1'b0;
      rx_err        <= 1'b0;
      rx_crc_err    <= 1'b0;
      rx_len_err    <= 1'b0;
      frames_ok     <= '0;
      frames_bad    <= '0;
    end else begin
      rx_valid   <= 1'b0;
      rx_last    <= 1'b0;
      rx_err     <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_len_err <= 1'b0;
      if (!RX_DV) dv_low_seen_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (RX_DV && dv_low_seen_q) begin
            if (RXD == Preamble) begin
              state_q <= StPreamble;
            end else if (RXD == Sfd) begin
              state_q <= StData;
              cnt_q   <= '0;
              crc_q   <= CrcInit;
              err_q   <= 1'b0;
            end else begin
              state_q <= StDrop;
            end
          end
        end

        StPreamble: begin
          if (!RX_DV) begin
            state_q <= StIdle;
          end else if (RXD == Sfd) begin
            state_q <= StData;
            cnt_q   <= '0;
            crc_q   <= CrcInit;
            err_q   <= 1'b0;
          end else if (RXD != Preamble) begin
            state_q <= StDrop;
          end
        end

        StData: begin
          if (RX_DV) begin
            crc_q <= crc_byte(crc_q, RXD);
            sr_q  <= {sr_q[3:0], RXD};
            cnt_q <= cnt_inc;
            err_q <= err_q | RX_ER;
            if (cnt_ge5) begin
              rx_data  <= sr_q[4];
              rx_valid <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
            if (cnt_ge5) begin
              // sr_q[3:0] hold the FCS and are simply left behind.
              rx_data    <= sr_q[4];
              rx_valid   <= 1'b1;
              rx_last    <= 1'b1;
              rx_err     <= err_q;
              rx_crc_err <= crc_bad;
              rx_len_err <= len_bad;
              if (frame_bad) frames_bad <= bad_inc;
              else           frames_ok  <= ok_inc;
            end else begin
              frames_bad <= bad_inc;
            end
          end
        end

        StDrop: begin
          if (!RX_DV) begin
            state_q    <= StIdle;
            frames_bad <= bad_inc;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_framer.sv
// Directed bench for mac_rx_framer: table of whole-frame vectors plus hand-written
// sequences for preamble abort and reset mid-frame.
module tb_mac_rx_framer;

  logic        clk;
  logic        reset;
  logic        RX_DV;
  logic        RX_ER;
  logic [7:0]  RXD;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_err;
  logic        rx_crc_err;
  logic        rx_len_err;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  mac_rx_framer #(
    .MIN_LEN(64),
    .MAX_LEN(1522)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RX_DV     (RX_DV),
    .RX_ER     (RX_ER),
    .RXD       (RXD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_last   (rx_last),
    .rx_err    (rx_err),
    .rx_crc_err(rx_crc_err),
    .rx_len_err(rx_len_err),
    .frames_ok (frames_ok),
    .frames_bad(frames_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         pre;        // number of 0x55 bytes
    logic [7:0] sfd;        // byte sent after the preamble
    int         n;          // payload bytes (DA onward, before FCS)
    bit         fcs;        // append computed FCS
    bit         flip;       // flip bit 0 of FCS byte 0
    int         er_at;      // payload index carrying RX_ER, -1 for none
    int         exp_bytes;
    bit         exp_last;
    bit         exp_err;
    bit         exp_crc;
    bit         exp_len;
    int         d_ok;
    int         d_bad;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ok   = 0;
  int exp_bad  = 0;

  // Monitor state (written only by the monitor process).
  logic [7:0] got_q[$];
  int         last_cnt  = 0;
  int         last_idx  = -1;
  logic       last_err  = 1'b0;
  logic       last_crc  = 1'b0;
  logic       last_len  = 1'b0;
  int         flag_viol = 0;

  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (rx_last) begin
        last_cnt = last_cnt + 1;
        last_idx = got_q.size() - 1;
        last_err = rx_err;
        last_crc = rx_crc_err;
        last_len = rx_len_err;
        if (!rx_valid) flag_viol = flag_viol + 1;
      end else if (rx_err || rx_crc_err || rx_len_err) begin
        flag_viol = flag_viol + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Bit-serial CRC-32 (reflected 0xEDB88320).
  function automatic logic [31:0] crc32(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = crc;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  function automatic vec_t mk(input int pre, input logic [7:0] sfd, input int n, input bit fcs,
                              input bit flip, input int er_at, input int eb, input bit el,
                              input bit ee, input bit ec, input bit elen, input int dok,
                              input int dbad);
    vec_t v;
    v.pre = pre; v.sfd = sfd; v.n = n; v.fcs = fcs; v.flip = flip; v.er_at = er_at;
    v.exp_bytes = eb; v.exp_last = el; v.exp_err = ee; v.exp_crc = ec; v.exp_len = elen;
    v.d_ok = dok; v.d_bad = dbad;
    return v;
  endfunction

  task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
    RX_DV = dv; RX_ER = er; RXD = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pay(input int seed, input int i);
    return 8'((i * 13 + seed) & 255);
  endfunction

  // Send one frame, leave RX_DV low for exactly the fall cycle, then check it.
  task automatic run_frame(input string tag, input vec_t v, input int seed);
    int          base;
    int          lbase;
    int          got_n;
    int          mism;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    base  = got_q.size();
    lbase = last_cnt;
    exp_q.delete();
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < v.pre; i++) cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, v.sfd);
    for (int i = 0; i < v.n; i++) begin
      b = pay(seed, i);
      exp_q.push_back(b);
      crc = crc32(crc, b);
      cyc(1'b1, (i == v.er_at), b);
    end
    if (v.fcs) begin
      fcs = ~crc;
      for (int k = 0; k < 4; k++) begin
        b = fcs[8*k +: 8];
        if (k == 0 && v.flip) b = b ^ 8'h01;
        cyc(1'b1, 1'b0, b);
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    exp_ok  += v.d_ok;
    exp_bad += v.d_bad;
    got_n = got_q.size() - base;
    mism  = 0;
    for (int i = 0; i < got_n; i++)
      if (i >= exp_q.size() || got_q[base + i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, got_n, v.exp_bytes);
    chk({tag, "_data"}, mism, 0);
    chk({tag, "_last_cnt"}, last_cnt - lbase, {31'd0, v.exp_last});
    if (v.exp_last) begin
      chk({tag, "_last_pos"}, last_idx - base, v.exp_bytes - 1);
      chk({tag, "_rx_err"}, {31'd0, last_err}, {31'd0, v.exp_err});
      chk({tag, "_crc_err"}, {31'd0, last_crc}, {31'd0, v.exp_crc});
      chk({tag, "_len_err"}, {31'd0, last_len}, {31'd0, v.exp_len});
    end
    chk({tag, "_frames_ok"}, {16'd0, frames_ok}, exp_ok);
    chk({tag, "_frames_bad"}, {16'd0, frames_bad}, exp_bad);
  endtask

  vec_t vecs[14];
  vec_t good64;

  initial begin
    int base;
    reset = 1'b1;
    RX_DV = 1'b0; RX_ER = 1'b0; RXD = 8'h00;

    vecs[0]  = mk(7, 8'hD5,   60, 1, 0, -1,   60, 1, 0, 0, 0, 1, 0); // good 64
    vecs[1]  = mk(7, 8'hD5,   60, 1, 1, -1,   60, 1, 0, 1, 0, 0, 1); // FCS bit flip
    vecs[2]  = mk(7, 8'h5D,   60, 1, 0, -1,    0, 0, 0, 0, 0, 0, 1); // bad SFD
    vecs[3]  = mk(7, 8'hD5,   60, 1, 0, 20,   60, 1, 1, 0, 0, 0, 1); // RX_ER at byte 20
    vecs[4]  = mk(7, 8'hD5,    3, 0, 0, -1,    0, 0, 0, 0, 0, 0, 1); // 3 bytes after SFD
    vecs[5]  = mk(7, 8'hD5,   36, 1, 0, -1,   36, 1, 0, 0, 1, 0, 1); // 40-byte runt
    vecs[6]  = mk(0, 8'hD5,   60, 1, 0, -1,   60, 1, 0, 0, 0, 1, 0); // no preamble
    vecs[7]  = mk(0, 8'h12,   10, 0, 0, -1,    0, 0, 0, 0, 0, 0, 1); // garbage in IDLE
    vecs[8]  = mk(7, 8'hD5,   59, 1, 0, -1,   59, 1, 0, 0, 1, 0, 1); // 63 bytes
    vecs[9]  = mk(7, 8'hD5, 1518, 1, 0, -1, 1518, 1, 0, 0, 0, 1, 0); // 1522 bytes
    vecs[10] = mk(7, 8'hD5, 1519, 1, 0, -1, 1519, 1, 0, 0, 1, 0, 1); // 1523 bytes
    vecs[11] = mk(7, 8'hD5,    1, 1, 0, -1,    1, 1, 0, 0, 1, 0, 1); // exactly 5 bytes
    vecs[12] = mk(7, 8'hD5,    0, 1, 0, -1,    0, 0, 0, 0, 0, 0, 1); // exactly 4 bytes
    vecs[13] = mk(2, 8'hD5,   60, 1, 0, -1,   60, 1, 0, 0, 0, 1, 0); // short preamble
    good64   = vecs[0];

    // Reset state.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_last", {31'd0, rx_last}, 0);
    chk("rst_flags", {29'd0, rx_err, rx_crc_err, rx_len_err}, 0);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_frames_ok", {16'd0, frames_ok}, 0);
    chk("rst_frames_bad", {16'd0, frames_bad}, 0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Table vectors, back to back with a single idle cycle between frames.
    for (int v = 0; v < 14; v++) run_frame($sformatf("v%0d", v), vecs[v], v * 31 + 1);

    // Preamble abandoned before SFD, then RX_ER with RX_DV low: nothing happens.
    base = got_q.size();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hD5);
    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("pre_abort_bytes", got_q.size() - base, 0);
    chk("pre_abort_ok", {16'd0, frames_ok}, exp_ok);
    chk("pre_abort_bad", {16'd0, frames_bad}, exp_bad);
    run_frame("after_abort", good64, 77);

    // Reset at data byte 30; burst continues 5 more bytes, good frame 12 cycles after reset.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, pay(5, i));
    reset = 1'b1;
    cyc(1'b1, 1'b0, pay(5, 30));
    reset = 1'b0;
    exp_ok  = 0;
    exp_bad = 0;
    base = got_q.size();
    for (int i = 31; i < 36; i++) cyc(1'b1, 1'b0, pay(5, i));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("rst_mid_bytes", got_q.size() - base, 0);
    chk("rst_mid_ok", {16'd0, frames_ok}, 0);
    chk("rst_mid_bad", {16'd0, frames_bad}, 0);
    run_frame("post_reset", good64, 99);

    chk("flags_outside_last", flag_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
